instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Boot-time controller for the core's word-addressed instruction memory. It owns the memory's single address port. After reset it holds the fetch stage stalled while it receives a program image byte-by-byte from the UART receiver, assembles little-endian words and writes them sequentially from word 0. When loading finishes it hands the address port to the fetch stage.

## Interface
Parameters:
- ADDR_W, 13, instruction memory word-address width (8192 words)
- MAX_WORDS, 8192, largest accepted image length in words; must not exceed 2^ADDR_W
- NOP_INSTR, 32'h00000013, instruction returned to the core while it is stalled

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- rx_valid_i  in  1  one-cycle strobe; a received UART byte is on rx_data_i
- rx_data_i  in  8  received byte
- skip_i  in  1  bypass loading and run the existing memory contents
- core_pc_i  in  32  fetch PC
- core_instr_o  out  32  instruction to the fetch stage
- core_stall_o  out  1  holds the fetch stage while not in RUN
- mem_addr_o  out  ADDR_W  instruction memory word address
- mem_we_o  out  1  instruction memory write enable
- mem_wdata_o  out  32  instruction memory write data
- mem_rdata_i  in  32  instruction memory read data (combinational read)
- boot_done_o  out  1  load complete, core released
- err_o  out  1  image length rejected

## Operation
- States: HDR, DATA, WR, RUN, ERR. Reset state is HDR. The byte counter (2 b), word index (ADDR_W+1 b), length register (32 b) and assembly register are cleared on reset.
- HDR: collects 4 length bytes, LSB first, giving N = {b3,b2,b1,b0}.
  - If skip_i=1 and the byte counter is 0, go to RUN on the next edge. No writes occur.
  - On the edge that samples the 4th length byte:
    - N=0 goes to RUN.
    - N>MAX_WORDS goes to ERR.
    - Otherwise go to DATA.
- DATA: bytes are assembled LSB first. On the edge that samples the 4th byte:
  - mem_wdata_o <= {byte3,byte2,byte1,byte0}.
  - The registered write address <= word index.
  - mem_we_o <= 1.
  - Go to WR.
- WR: lasts exactly one cycle with mem_we_o=1. On exit the word index increments.
  - If the index after increment equals N, go to RUN.
  - Otherwise go to DATA.
  - A byte that arrives during WR is accepted as byte 0 of the next word. No byte is ever dropped.
- RUN: terminal until reset.
  - mem_addr_o = core_pc_i[ADDR_W+1:2], combinational. PC bits [1:0] are ignored; higher bits are truncated, so addresses wrap.
  - core_instr_o = mem_rdata_i.
  - mem_we_o=0, core_stall_o=0, boot_done_o=1.
  - rx_valid_i is ignored.
- ERR: terminal until reset.
  - err_o=1, core_stall_o=1, mem_we_o=0.
  - rx_valid_i is ignored.
- Outside RUN: core_instr_o = NOP_INSTR and mem_addr_o = the registered write address.
- The length comparison is done at 32-bit width, with the word index zero-extended.

## Timing
- Reset values: core_stall_o=1, boot_done_o=0, err_o=0, mem_we_o=0, mem_wdata_o=0, mem_addr_o=0, core_instr_o=NOP_INSTR.
- Reset asserted mid-load returns to HDR immediately. Words already written stay in memory; the next image overwrites them from word 0.
- Write latency: mem_we_o is high for exactly the one cycle after the edge that sampled the word's 4th byte.
- Release: core_stall_o falls and boot_done_o rises the cycle after the last write cycle. For N=0 or skip, they change the cycle after the deciding edge.
- Back-to-back rx_valid_i on consecutive cycles must be sustained in both DATA and WR.
- Every output except mem_addr_o and core_instr_o in RUN is registered or decoded from the state register.

## Test plan
- Reset: assert rst_i asynchronously mid-cycle. All outputs must take their reset values immediately and core_instr_o=0x00000013.
- Two-word load: send 02 00 00 00, 37 05 00 20, 93 84 54 0a.
  - Expect writes addr0=0x20000537 and addr1=0x0a548493, each a single-cycle mem_we_o.
  - Stall drops one cycle after the second write.
  - Then pc=0x4 must give core_instr_o=0x0a548493.
- Zero length: send 00 00 00 00. RUN the next cycle, no mem_we_o pulse, boot_done_o=1.
- Oversize: send 01 20 00 00 (N=8193).
  - err_o=1, stall held.
  - 8 further bytes produce no writes.
- Skip and back-to-back:
  - skip_i=1 in HDR: RUN next cycle.
  - Separately, stream a 3-word image with rx_valid_i high every cycle: all 3 words are written correctly.
- Reset mid-load: after 6 bytes of an image, pulse rst_i, then send a full one-word image. Word 0 must hold the new word and the state must reach RUN.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Boot loader for the instruction memory: receives a length-prefixed image
// over UART bytes, writes it from word 0, then hands the port to fetch.
module instr_mem_loader #(
  parameter int          ADDR_W    = 13,
  parameter int          MAX_WORDS = 8192,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              skip_i,
  input  logic [31:0]       core_pc_i,
  output logic [31:0]       core_instr_o,
  output logic              core_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              boot_done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    HDR,
    DATA,
    WR,
    RUN,
    ERR
  } state_t;

  localparam logic [31:0] MAXW = MAX_WORDS;

  state_t            r_state;
  logic [1:0]        r_bcnt;
  logic [ADDR_W:0]   r_widx;
  logic [31:0]       r_len;
  logic [23:0]       r_asm;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_we;

  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_widx_nx;
  logic              w_accept;
  logic              w_run;
  logic              w_unused_pc;

  assign w_word    = {rx_data_i, r_asm};
  assign w_widx_nx = r_widx + 1'b1;
  assign w_run     = (r_state == RUN);
  // Bytes are taken in WR too, so a back-to-back stream never loses one.
  assign w_accept  = rx_valid_i &&
                     ((r_state == HDR) ||
                      (r_state == DATA) ||
                      (r_state == WR));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= HDR;
      r_bcnt  <= '0;
      r_widx  <= '0;
      r_len   <= '0;
      r_asm   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        r_bcnt <= r_bcnt + 2'd1;
        case (r_bcnt)
          2'd0:    r_asm[7:0]   <= rx_data_i;
          2'd1:    r_asm[15:8]  <= rx_data_i;
          2'd2:    r_asm[23:16] <= rx_data_i;
          default: ;
        endcase
      end
      case (r_state)
        HDR: begin
          if (skip_i && (r_bcnt == 2'd0)) begin
            r_state <= RUN;
          end else if (rx_valid_i && (r_bcnt == 2'd3)) begin
            r_len <= w_word;
            if (w_word == 32'd0)
              r_state <= RUN;
            else if (w_word > MAXW)
              r_state <= ERR;
            else
              r_state <= DATA;
          end
        end
        DATA: begin
          if (rx_valid_i && (r_bcnt == 2'd3)) begin
            r_wdata <= w_word;
            r_waddr <= r_widx[ADDR_W-1:0];
            r_we    <= 1'b1;
            r_state <= WR;
          end
        end
        WR: begin
          r_widx <= w_widx_nx;
          if (32'(w_widx_nx) == r_len)
            r_state <= RUN;
          else
            r_state <= DATA;
        end
        default: ;
      endcase
    end
  end

  assign w_unused_pc  = ^{core_pc_i[31:ADDR_W+2], core_pc_i[1:0]};

  assign mem_addr_o   = w_run ? core_pc_i[ADDR_W+1:2] : r_waddr;
  assign core_instr_o = w_run ? mem_rdata_i : NOP_INSTR;
  assign mem_we_o     = r_we;
  assign mem_wdata_o  = r_wdata;
  assign core_stall_o = !w_run;
  assign boot_done_o  = w_run;
  assign err_o        = (r_state == ERR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a behavioural memory and a
// write monitor; each scenario task checks its own expectations.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        skip = 1'b0;
  logic [31:0] core_pc = 32'h0;
  logic [31:0] core_instr;
  logic        core_stall;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        boot_done;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] tb_mem [0:8191];
  logic [12:0] wa [$];
  logic [31:0] wd [$];
  int          dbl = 0;
  logic        prev_we = 1'b0;

  instr_mem_loader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .skip_i       (skip),
    .core_pc_i    (core_pc),
    .core_instr_o (core_instr),
    .core_stall_o (core_stall),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .boot_done_o  (boot_done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr];

  always @(posedge clk)
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      if (prev_we) dbl++;
    end
    prev_we = mem_we;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wa.delete();
    wd.delete();
    dbl = 0;
  endtask

  task automatic test_two_word();
    logic [7:0] b [12];
    b = '{8'h02, 8'h00, 8'h00, 8'h00,
          8'h37, 8'h05, 8'h00, 8'h20,
          8'h93, 8'h84, 8'h54, 8'h0a};
    for (int i = 0; i < 4; i++) begin
      put(b[i]); idle(1);
    end
    vectors++;
    if ({core_stall, boot_done, mem_we, core_instr} !== {3'b100, 32'h13}) begin
      miscompares++;
      $display("FAIL hdr_done: stall/done/we=%b%b%b instr=%h want 100 00000013",
               core_stall, boot_done, mem_we, core_instr);
    end
    for (int i = 4; i < 8; i++) begin
      put(b[i]);
      if (i != 7) idle(1);
    end
    vectors++;
    if ({mem_we, mem_addr, mem_wdata, core_stall} !== {1'b1, 13'd0, 32'h20000537, 1'b1}) begin
      miscompares++;
      $display("FAIL wr0: we=%b addr=%h data=%h stall=%b want 1 0000 20000537 1",
               mem_we, mem_addr, mem_wdata, core_stall);
    end
    idle(1);
    vectors++;
    if ({mem_we, core_stall} !== 2'b01) begin
      miscompares++;
      $display("FAIL wr0_pulse: we=%b stall=%b want 0 1", mem_we, core_stall);
    end
    for (int i = 8; i < 12; i++) begin
      put(b[i]);
      if (i != 11) idle(1);
    end
    vectors++;
    if ({mem_we, mem_addr, mem_wdata, core_stall} !== {1'b1, 13'd1, 32'h0a548493, 1'b1}) begin
      miscompares++;
      $display("FAIL wr1: we=%b addr=%h data=%h stall=%b want 1 0001 0a548493 1",
               mem_we, mem_addr, mem_wdata, core_stall);
    end
    idle(1);
    vectors++;
    if ({mem_we, core_stall, boot_done, err} !== 4'b0010) begin
      miscompares++;
      $display("FAIL release: we/stall/done/err=%b%b%b%b want 0010",
               mem_we, core_stall, boot_done, err);
    end
    core_pc = 32'h4; #1;
    vectors++;
    if ({mem_addr, core_instr} !== {13'd1, 32'h0a548493}) begin
      miscompares++;
      $display("FAIL fetch_pc4: addr=%h instr=%h want 0001 0a548493", mem_addr, core_instr);
    end
    core_pc = 32'h8007; #1;
    vectors++;
    if ({mem_addr, core_instr} !== {13'd1, 32'h0a548493}) begin
      miscompares++;
      $display("FAIL fetch_wrap: addr=%h instr=%h want 0001 0a548493", mem_addr, core_instr);
    end
    core_pc = 32'h0; #1;
    vectors++;
    if (core_instr !== 32'h20000537) begin
      miscompares++;
      $display("FAIL fetch_pc0: instr=%h want 20000537", core_instr);
    end
    vectors++;
    if (wa.size() != 2 || dbl != 0) begin
      miscompares++;
      $display("FAIL two_word_writes: count=%0d doubles=%0d want 2 0", wa.size(), dbl);
    end
    core_pc = 32'h8;
  endtask

  task automatic test_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({core_stall, boot_done, err, mem_we, mem_wdata, mem_addr, core_instr} !==
        {4'b1000, 32'h0, 13'h0, 32'h13}) begin
      miscompares++;
      $display("FAIL reset: stall/done/err/we=%b%b%b%b wdata=%h addr=%h instr=%h want 1000 0 0 00000013",
               core_stall, boot_done, err, mem_we, mem_wdata, mem_addr, core_instr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    core_pc = 32'h0;
    wa.delete();
    wd.delete();
  endtask

  task automatic test_zero_len();
    do_reset();
    put(8'h00); put(8'h00); put(8'h00);
    vectors++;
    if ({core_stall, boot_done} !== 2'b10) begin
      miscompares++;
      $display("FAIL zero_pre: stall/done=%b%b want 10", core_stall, boot_done);
    end
    put(8'h00);
    vectors++;
    if ({core_stall, boot_done, err, mem_we} !== 4'b0100 || wa.size() != 0) begin
      miscompares++;
      $display("FAIL zero_len: stall/done/err/we=%b%b%b%b writes=%0d want 0100 0",
               core_stall, boot_done, err, mem_we, wa.size());
    end
  endtask

  task automatic test_oversize();
    do_reset();
    put(8'h01); put(8'h20); put(8'h00); put(8'h00);
    vectors++;
    if ({err, core_stall, boot_done} !== 3'b110) begin
      miscompares++;
      $display("FAIL oversize: err/stall/done=%b%b%b want 110", err, core_stall, boot_done);
    end
    for (int i = 0; i < 8; i++) put(8'(i + 8'h40));
    idle(2);
    vectors++;
    if ({err, core_stall, mem_we} !== 3'b110 || wa.size() != 0) begin
      miscompares++;
      $display("FAIL err_sticky: err/stall/we=%b%b%b writes=%0d want 110 0",
               err, core_stall, mem_we, wa.size());
    end
  endtask

  task automatic test_boundary_len();
    do_reset();
    put(8'h00); put(8'h20); put(8'h00); put(8'h00);
    vectors++;
    if ({err, core_stall, boot_done} !== 3'b010) begin
      miscompares++;
      $display("FAIL len_max: err/stall/done=%b%b%b want 010", err, core_stall, boot_done);
    end
  endtask

  task automatic test_skip();
    do_reset();
    skip = 1'b1;
    @(posedge clk); #1;
    skip = 1'b0;
    vectors++;
    if ({core_stall, boot_done, err} !== 3'b010 || wa.size() != 0) begin
      miscompares++;
      $display("FAIL skip: stall/done/err=%b%b%b writes=%0d want 010 0",
               core_stall, boot_done, err, wa.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  b [16];
    logic [31:0] exp [3];
    b = '{8'h03, 8'h00, 8'h00, 8'h00,
          8'h44, 8'h33, 8'h22, 8'h11,
          8'h88, 8'h77, 8'h66, 8'h55,
          8'hef, 8'hbe, 8'had, 8'hde};
    exp = '{32'h11223344, 32'h55667788, 32'hdeadbeef};
    do_reset();
    for (int i = 0; i < 16; i++) put(b[i]);
    vectors++;
    if ({mem_we, core_stall} !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_last_wr: we/stall=%b%b want 11", mem_we, core_stall);
    end
    idle(1);
    vectors++;
    if ({core_stall, boot_done} !== 2'b01 || wa.size() != 3 || dbl != 0) begin
      miscompares++;
      $display("FAIL b2b_done: stall/done=%b%b writes=%0d doubles=%0d want 01 3 0",
               core_stall, boot_done, wa.size(), dbl);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (tb_mem[i] !== exp[i] ||
          (wa.size() > i && (wa[i] !== 13'(i) || wd[i] !== exp[i]))) begin
        miscompares++;
        $display("FAIL b2b_word%0d: mem=%h want %h", i, tb_mem[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    put(8'h01); put(8'h00); put(8'h00); put(8'h00);
    put(8'haa); put(8'hbb);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({core_stall, mem_we, mem_addr} !== {2'b10, 13'h0}) begin
      miscompares++;
      $display("FAIL mid_reset: stall/we=%b%b addr=%h want 10 0", core_stall, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    put(8'h01); put(8'h00); put(8'h00); put(8'h00);
    put(8'h78); put(8'h56); put(8'h34); put(8'h12);
    idle(1);
    vectors++;
    if (tb_mem[0] !== 32'h12345678 || boot_done !== 1'b1 || wa.size() != 1) begin
      miscompares++;
      $display("FAIL reload: mem0=%h done=%b writes=%0d want 12345678 1 1",
               tb_mem[0], boot_done, wa.size());
    end
    vectors++;
    if (tb_mem[1] !== 32'h55667788) begin
      miscompares++;
      $display("FAIL reload_keep: mem1=%h want 55667788", tb_mem[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) tb_mem[i] = 32'h0;
    do_reset();
    test_two_word();
    test_reset();
    test_zero_len();
    test_oversize();
    test_boundary_len();
    test_skip();
    test_back_to_back();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
